// File: rtl/step_rate_meter.sv
// rtl/step_rate_meter.sv - step pulse rate meter: per-second window counts, tick and running total
// Optional STEP_RATE_AVG_EN: ppm reports the mean of the last four saturated window counts.

module step_rate_meter #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned PPM_W         = 10,
  parameter int unsigned TOTAL_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pulse_in,
  output logic [PPM_W-1:0]   ppm,
  output logic               ppm_valid,
  output logic               second_tick,
  output logic [TOTAL_W-1:0] total_steps,
  output logic               running
);

  localparam int unsigned         PRE_W     = $clog2(TICKS_PER_SEC);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PPM_W:0]      WIN_SAT   = {1'b1, {PPM_W{1'b0}}};
  localparam logic [PPM_W-1:0]    PPM_MAX   = {PPM_W{1'b1}};
  localparam logic [TOTAL_W-1:0]  TOTAL_MAX = {TOTAL_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q;
  logic               running_q;
  logic               sync1_q, sync2_q, prev_q;
  logic               step_edge;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [PPM_W:0]     win_q, win_d;
  logic [PPM_W-1:0]   win_sat;
  logic [PPM_W-1:0]   ppm_q, ppm_d;
  logic               tick_q, tick_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               in_run, terminal;
`ifdef STEP_RATE_AVG_EN
  logic [PPM_W-1:0]   h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
  logic [PPM_W+1:0]   avg_sum;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (!start) begin
          state_q   <= HOLD;
          running_q <= 1'b0;
        end
        HOLD: if (start) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Synchronizer tracks pulse_in in every state so a resume never sees a stale edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign step_edge = sync2_q & ~prev_q;

  always_comb begin
    in_run   = (state_q == RUN);
    terminal = in_run && (presc_q == PRE_LAST);
    win_sat  = win_q[PPM_W] ? PPM_MAX : win_q[PPM_W-1:0];
    presc_d  = presc_q;
    win_d    = win_q;
    ppm_d    = ppm_q;
    tick_d   = 1'b0;
    total_d  = total_q;
`ifdef STEP_RATE_AVG_EN
    h1_d     = h1_q;
    h2_d     = h2_q;
    h3_d     = h3_q;
    avg_sum  = {2'b00, win_sat} + {2'b00, h1_q} + {2'b00, h2_q} + {2'b00, h3_q};
`endif
    if (in_run) begin
      if (step_edge && (total_q != TOTAL_MAX)) begin
        total_d = total_q + 1'b1;
      end
      if (terminal) begin
        // An edge landing in the terminal cycle opens the next window.
        presc_d = '0;
        tick_d  = 1'b1;
        win_d   = {{PPM_W{1'b0}}, step_edge};
`ifdef STEP_RATE_AVG_EN
        ppm_d   = avg_sum[PPM_W+1:2];
        h1_d    = win_sat;
        h2_d    = h1_q;
        h3_d    = h2_q;
`else
        ppm_d   = win_sat;
`endif
      end else begin
        presc_d = presc_q + 1'b1;
        if (step_edge && (win_q != WIN_SAT)) begin
          win_d = win_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      win_q   <= '0;
      ppm_q   <= '0;
      tick_q  <= 1'b0;
      total_q <= '0;
`ifdef STEP_RATE_AVG_EN
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
`endif
    end else begin
      presc_q <= presc_d;
      win_q   <= win_d;
      ppm_q   <= ppm_d;
      tick_q  <= tick_d;
      total_q <= total_d;
`ifdef STEP_RATE_AVG_EN
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
`endif
    end
  end

  assign ppm         = ppm_q;
  assign ppm_valid   = tick_q;
  assign second_tick = tick_q;
  assign total_steps = total_q;
  assign running     = running_q;

endmodule
